// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // wait_cnt must be able to hold MEM_TIMEOUT itself.
  function automatic int wait_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hazard_sequencer_load_use_detect.sv
// Load-use comparator: a load in ID/EX whose target is read by the instruction in ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  logic rs_match, rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  // $zero never carries a real dependency.
  assign hazard   = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall controller: load-use stalls, data-memory wait states, branch flush, timeout halt.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_BranchTaken,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             MEM_Access,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             MEMWB_Bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = wait_cnt_w(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_hold;
  logic              lu_raw, load_use;

  load_use_detect u_lud (
    .id_rs       (ID_Rs),
    .id_rt       (ID_Rt),
    .id_uses_rt  (ID_UsesRt),
    .ex_mem_read (EX_MemRead),
    .ex_rt       (EX_Rt),
    .hazard      (lu_raw)
  );

  // Hold is asserted from the very first cycle of a non-zero-wait access so EX/MEM keeps the access.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_hold     = 1'b0;
    case (state)
      RUN: begin
        if (MEM_Access && !mem_ack) begin
          mem_hold     = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          mem_hold = 1'b1;
          if (wait_cnt == WAIT_LAST) state_nxt = HALT;
          else                       wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      HALT:    mem_hold = 1'b1;
      default: begin
        mem_hold  = 1'b1;
        state_nxt = RUN;
      end
    endcase
  end

  assign load_use = lu_raw && (state == RUN) && !mem_hold;

  always_comb begin
    mem_req      = MEM_Access && (state != HALT);
    PC_Write     = !(mem_hold || load_use);
    IFID_Write   = !(mem_hold || load_use);
    IDEX_Write   = !mem_hold;
    EXMEM_Write  = !mem_hold;
    MEMWB_Bubble = mem_hold;
    IDEX_Bubble  = load_use;
    IFID_Flush   = ID_BranchTaken && !mem_hold && !load_use;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err || (state_nxt == HALT);
      if (!PC_Write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_hazard_sequencer;

  localparam int TO = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    ID_Rs, ID_Rt, EX_Rt;
  logic          ID_UsesRt, ID_BranchTaken, EX_MemRead, MEM_Access, mem_ack;
  logic          mem_req, PC_Write, IFID_Write, IDEX_Write, EXMEM_Write;
  logic          IFID_Flush, IDEX_Bubble, MEMWB_Bubble, mem_err;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_BranchTaken(ID_BranchTaken),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .MEM_Access(MEM_Access), .mem_ack(mem_ack),
    .mem_req(mem_req), .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .EXMEM_Write(EXMEM_Write), .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
    .MEMWB_Bubble(MEMWB_Bubble), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  // ctrl bit order: {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, mem_req}
  localparam logic [7:0] C_IDLE  = 8'b1111_0000;
  localparam logic [7:0] C_LU    = 8'b0011_0100;
  localparam logic [7:0] C_FLUSH = 8'b1111_1000;
  localparam logic [7:0] C_ACC   = 8'b1111_0001;
  localparam logic [7:0] C_HOLD  = 8'b0000_0011;
  localparam logic [7:0] C_HALT  = 8'b0000_0010;
  localparam logic [7:0] M_ALL   = 8'hFF;
  localparam logic [7:0] M_NOFB  = 8'b1111_0011;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs, rt;
    logic       uses_rt, br, mr;
    logic [4:0] ex_rt;
    logic       acc, ack;
  } in_t;

  typedef struct packed {
    logic [7:0]    ctrl;
    logic [7:0]    mask;
    logic          err;
    logic [CW-1:0] st;
    int            idx;
  } exp_t;

  exp_t q[$];
  in_t  nx;
  int   tests = 0;
  int   fails = 0;
  int   step_no = 0;

  task automatic idle_in();
    nx = '{rst_n: 1'b1, default: '0};
  endtask

  // Apply nx just after the edge and queue what the outputs must show this cycle.
  task automatic cyc(input logic [7:0] c, input logic e, input int s, input logic [7:0] m = M_ALL);
    @(posedge clk);
    #1;
    rst_n = nx.rst_n; ID_Rs = nx.rs; ID_Rt = nx.rt; ID_UsesRt = nx.uses_rt;
    ID_BranchTaken = nx.br; EX_MemRead = nx.mr; EX_Rt = nx.ex_rt;
    MEM_Access = nx.acc; mem_ack = nx.ack;
    q.push_back('{ctrl: c, mask: m, err: e, st: CW'(s), idx: step_no});
    step_no++;
  endtask

  task automatic do_reset();
    idle_in();
    nx.rst_n = 1'b0;
    cyc(C_IDLE, 1'b0, 0);
    idle_in();
    cyc(C_IDLE, 1'b0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [7:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, mem_req};
      tests++;
      if ((act & e.mask) !== (e.ctrl & e.mask)) begin
        fails++;
        $display("FAIL ctrl step %0d: got %b want %b (mask %b)", e.idx, act, e.ctrl, e.mask);
      end
      tests++;
      if (mem_err !== e.err) begin
        fails++;
        $display("FAIL mem_err step %0d: got %b want %b", e.idx, mem_err, e.err);
      end
      tests++;
      if (stall_cycles !== e.st) begin
        fails++;
        $display("FAIL stall_cycles step %0d: got %0d want %0d", e.idx, stall_cycles, e.st);
      end
    end
  end

  initial begin
    idle_in();
    rst_n = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0; ID_BranchTaken = 1'b0;
    EX_MemRead = 1'b0; EX_Rt = '0; MEM_Access = 1'b0; mem_ack = 1'b0;

    do_reset();

    // Load-use on Rs: one stall cycle.
    nx.mr = 1'b1; nx.ex_rt = 5'd8; nx.rs = 5'd8;
    cyc(C_LU, 1'b0, 0);
    idle_in();
    cyc(C_IDLE, 1'b0, 1);

    // Load to $zero, and unused Rt: no stall; then Rt used: stall.
    nx.mr = 1'b1; nx.ex_rt = 5'd0; nx.rs = 5'd0; nx.rt = 5'd0; nx.uses_rt = 1'b1;
    cyc(C_IDLE, 1'b0, 1);
    idle_in();
    nx.mr = 1'b1; nx.ex_rt = 5'd9; nx.rt = 5'd9; nx.rs = 5'd3; nx.uses_rt = 1'b0;
    cyc(C_IDLE, 1'b0, 1);
    nx.uses_rt = 1'b1;
    cyc(C_LU, 1'b0, 1);
    idle_in();
    cyc(C_IDLE, 1'b0, 2);

    // Plain branch flush, zero-wait access, stray ack.
    nx.br = 1'b1;
    cyc(C_FLUSH, 1'b0, 2);
    idle_in();
    nx.acc = 1'b1; nx.ack = 1'b1;
    cyc(C_ACC, 1'b0, 2);
    idle_in();
    nx.ack = 1'b1;
    cyc(C_IDLE, 1'b0, 2);

    // 4-cycle memory: 3 hold cycles, advance on the 4th edge.
    do_reset();
    nx.acc = 1'b1;
    cyc(C_HOLD, 1'b0, 0);
    cyc(C_HOLD, 1'b0, 1);
    cyc(C_HOLD, 1'b0, 2);
    nx.ack = 1'b1;
    cyc(C_ACC, 1'b0, 3);
    idle_in();
    cyc(C_IDLE, 1'b0, 3);

    // Memory wait overlapping load-use and a taken branch.
    do_reset();
    nx.acc = 1'b1; nx.mr = 1'b1; nx.ex_rt = 5'd8; nx.rs = 5'd8; nx.br = 1'b1;
    cyc(C_HOLD, 1'b0, 0);
    cyc(C_HOLD, 1'b0, 1);
    cyc(C_HOLD, 1'b0, 2);
    nx.ack = 1'b1;
    cyc(C_ACC, 1'b0, 3, M_NOFB);
    nx.acc = 1'b0; nx.ack = 1'b0;
    cyc(C_LU, 1'b0, 3);
    nx.mr = 1'b0;
    cyc(C_FLUSH, 1'b0, 4);
    idle_in();
    cyc(C_IDLE, 1'b0, 4);

    // Timeout: no ack, HALT after 4 wait cycles; counter saturates at 7.
    do_reset();
    nx.acc = 1'b1;
    cyc(C_HOLD, 1'b0, 0);
    cyc(C_HOLD, 1'b0, 1);
    cyc(C_HOLD, 1'b0, 2);
    cyc(C_HOLD, 1'b0, 3);
    cyc(C_HOLD, 1'b0, 4);
    cyc(C_HALT, 1'b1, 5);
    nx.mr = 1'b1; nx.ex_rt = 5'd8; nx.rs = 5'd8; nx.br = 1'b1; nx.ack = 1'b1;
    cyc(C_HALT, 1'b1, 6);
    cyc(C_HALT, 1'b1, 7);
    cyc(C_HALT, 1'b1, 7);
    idle_in();
    nx.rst_n = 1'b0;
    cyc(C_IDLE, 1'b0, 0);
    idle_in();
    cyc(C_IDLE, 1'b0, 0);

    // Counter saturation from a long load-use stall.
    nx.mr = 1'b1; nx.ex_rt = 5'd5; nx.rs = 5'd5;
    for (int i = 0; i < 9; i++) cyc(C_LU, 1'b0, (i > 7) ? 7 : i);
    idle_in();
    cyc(C_IDLE, 1'b0, 7);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall controller for the 5-stage MIPS core. It detects load-use hazards between the ID stage and the ID/EX register, sequences multi-cycle data-memory wait states, and flushes IF/ID on taken branches. It drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. A memory timeout halts the pipeline with a sticky error.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before a halt (must be ≥1).
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads Rt (R-type, store, beq).
- ID_BranchTaken  in  1  branch in ID resolved taken.
- EX_MemRead  in  1  MemRead output of the ID/EX register.
- EX_Rt  in  5  Rt output of the ID/EX register.
- MEM_Access  in  1  EX/MEM holds a load or store.
- mem_ack  in  1  data memory completion for the current access.
- mem_req  out  1  data memory access strobe.
- PC_Write, IFID_Write, IDEX_Write, EXMEM_Write  out  1 each  register enables (1 = advance).
- IFID_Flush  out  1  load a NOP into IF/ID.
- IDEX_Bubble  out  1  zero all control inputs into ID/EX.
- MEMWB_Bubble  out  1  zero the control inputs into MEM/WB.
- mem_err  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with PC_Write=0.

## Operation
- States: RUN, MEM_WAIT, HALT. Reset enters RUN and clears wait_cnt, stall_cycles and mem_err.
- mem_req = MEM_Access while in RUN or MEM_WAIT; 0 in HALT.
- RUN:
  - MEM_Access=1 and mem_ack=0 -> MEM_WAIT, with wait_cnt=1.
  - MEM_Access with mem_ack=1 in the same cycle is a zero-wait access and causes no stall.
- MEM_WAIT (mem_hold=1 while mem_ack=0):
  - mem_ack=1 -> RUN. The hold drops in the same cycle and the pipeline advances on that edge.
  - Otherwise, wait_cnt==MEM_TIMEOUT -> HALT and mem_err<=1; else wait_cnt++.
- HALT: absorbing until reset. mem_hold=1 permanently.
- mem_hold: PC_Write, IFID_Write, IDEX_Write and EXMEM_Write are all 0, MEMWB_Bubble=1, and load-use and flush are suppressed.
- Load-use (RUN, no mem_hold): EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)).
  - Effect: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, with IDEX_Write and EXMEM_Write left at 1.
- Branch flush: IFID_Flush = ID_BranchTaken && no mem_hold && no load-use.
  - A branch blocked by load-use re-resolves in the following cycle.
- Priority: HALT > mem_hold > load-use > flush.
- stall_cycles increments on every edge where PC_Write=0 and saturates at all-ones.
- With all inputs inactive, outputs are: PC_Write=IFID_Write=IDEX_Write=EXMEM_Write=1, all bubble/flush=0, mem_req=0, mem_err=0, stall_cycles=0. These are also the values during reset.

## Timing
- Control outputs are combinational from the state register and current inputs, with zero latency. They must settle within the cycle to gate the pipeline registers on the next edge.
- Only the state, wait_cnt, mem_err and stall_cycles are registered.
- Load-use costs exactly one stall cycle: on the next edge the load has moved to EX/MEM and the compare clears.
- An N-cycle memory (ack in the Nth cycle of the access) costs N-1 hold cycles.
- Load-use and a memory wait can overlap. The hold takes priority, and the load-use bubble is issued in the first RUN cycle after the ack.
- Reset asserted mid-MEM_WAIT or in HALT returns to RUN immediately (asynchronously) and clears mem_err. No partial access is retried by this block.
- mem_ack while in RUN with MEM_Access=0 is ignored.

## Structure
- hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT, HALT);
  - the REG_ZERO constant (5'd0);
  - the width derivation for wait_cnt ($clog2(MEM_TIMEOUT+1)).
- One sub-module, load_use_detect, is purely combinational: the register comparator described above.
- The FSM, counters and output-priority logic live in the top level.

## Test plan
- Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8 -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Bubble=1; stall_cycles 0->1.
- Load to $zero or unused Rt: EX_Rt=0, or EX_Rt=9 with ID_Rt=9 and ID_UsesRt=0 -> no stall.
- Memory wait: MEM_Access=1, mem_ack arrives in the 4th cycle -> 3 cycles with all Writes=0 and MEMWB_Bubble=1, advance on the 4th edge; stall_cycles=3.
- Timeout, MEM_TIMEOUT=4: ack never arrives -> HALT after 4 wait cycles, mem_err=1, mem_req=0, holds persist. Then assert rst_n=0 -> RUN, mem_err=0.
- Simultaneous events: memory wait + load-use + ID_BranchTaken -> only the hold acts while waiting. First cycle after the ack: IDEX_Bubble=1, IFID_Flush=0. Following cycle: IFID_Flush=1.
- Counter saturation with CNT_W=2: 5 stall cycles -> stall_cycles=3.
